// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group is resolved per stage. Each stage keeps the
// sum groups resolved so far, the operand groups still pending (skew buffer)
// and the carry into the next group. All stages advance together.
module cla_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = (BLOCK < 1) ? 1 : WIDTH / BLOCK;

   if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
      $error("cla_adder_pipe: WIDTH must be a positive multiple of BLOCK");
   end

   // Full lookahead for one group: returns {carry_out, sum}. Every internal
   // carry is a flat sum-of-products of generate/propagate terms and c0.
   function automatic logic [BLOCK:0] cla_group(
      input logic [BLOCK-1:0] x,
      input logic [BLOCK-1:0] y,
      input logic             c0
   );
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      logic             term;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = c0;
      for (int k = 1; k <= BLOCK; k++) begin
         term = c0;
         for (int m = 0; m < k; m++) term = term & p[m];
         c[k] = term;
         for (int j = 0; j < k; j++) begin
            term = g[j];
            for (int m = j + 1; m < k; m++) term = term & p[m];
            c[k] = c[k] | term;
         end
      end
      return {c[BLOCK], p ^ c[BLOCK-1:0]};
   endfunction

   // Whole pipeline moves when the output slot is empty or being drained.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * BLOCK;      // lowest bit of this stage's group
      localparam int PW = WIDTH - LO;      // operand bits still unresolved

      logic [PW-1:0]        a_src;
      logic [PW-1:0]        b_src;
      logic                 c_src;
      logic                 v_src;
      logic [BLOCK:0]       grp;
      logic [LO+BLOCK-1:0]  sum_new;

      logic                 v_q, v_d;
      logic                 c_q, c_d;
      logic [LO+BLOCK-1:0]  sum_q, sum_d;

      if (gi == 0) begin : g_src
         assign a_src   = a;
         assign b_src   = sub ? ~b : b;
         assign c_src   = cin ^ sub;
         assign v_src   = in_valid;
         assign sum_new = grp[BLOCK-1:0];
      end else begin : g_src
         assign a_src   = g_stage[gi-1].g_pend.a_q;
         assign b_src   = g_stage[gi-1].g_pend.b_q;
         assign c_src   = g_stage[gi-1].c_q;
         assign v_src   = g_stage[gi-1].v_q;
         assign sum_new = {grp[BLOCK-1:0], g_stage[gi-1].sum_q};
      end

      assign grp = cla_group(a_src[BLOCK-1:0], b_src[BLOCK-1:0], c_src);

      // Next state of this stage: load from upstream on advance, else hold.
      always_comb begin
         v_d   = adv ? v_src   : v_q;
         c_d   = adv ? grp[BLOCK] : c_q;
         sum_d = adv ? sum_new : sum_q;
      end

      // Stage registers, cleared by reset so no stale result survives.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            sum_q <= sum_d;
         end
      end

      if (gi < STAGES - 1) begin : g_pend
         logic [PW-BLOCK-1:0] a_q, a_d;
         logic [PW-BLOCK-1:0] b_q, b_d;

         // Skew buffer: pass the unresolved upper groups down the pipe.
         always_comb begin
            a_d = adv ? a_src[PW-1:BLOCK] : a_q;
            b_d = adv ? b_src[PW-1:BLOCK] : b_q;
         end

         // Pending operand registers.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_last
         logic cmsb_q, cmsb_d;

         // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
         always_comb begin
            cmsb_d = adv ? (a_src[PW-1] ^ b_src[PW-1] ^ grp[BLOCK-1]) : cmsb_q;
         end

         // Registered carry into the MSB for the overflow flag.
         always_ff @(posedge clk) begin
            if (!rst_n) cmsb_q <= 1'b0;
            else        cmsb_q <= cmsb_d;
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and streaming checks for cla_adder_pipe: a 16/4 instance and a
// single-stage 4/4 instance.
module tb_cla_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, sum;
   logic        cin, sub, cout, ovf;

   logic        in_valid1, in_ready1, out_valid1, out_ready1;
   logic [3:0]  a1, b1, sum1;
   logic        cin1, sub1, cout1, ovf1;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   cla_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   cla_adder_pipe #(.WIDTH(4), .BLOCK(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   // Arithmetic reference: returns {ovf, cout, sum}.
   function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
      logic [15:0] yy;
      logic [16:0] full;
      logic        o;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {16'd0, ci ^ s};
      o    = (x[15] == yy[15]) && (full[15] != x[15]);
      return {o, full[16], full[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
      checks++; if ({ovf, cout, sum} !== 18'd0) $display("FAIL reset_outputs got %h want 0", {ovf, cout, sum}); else passes++;
      checks++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid1 got %b want 0", out_valid1); else passes++;
      $display("reset: out_valid=%b in_ready=%b sum=%h", out_valid, in_ready, sum);
   endtask

   // One isolated op: checks 4-cycle latency and the result fields.
   task automatic run_single(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tc, input logic ts, input logic [15:0] es,
                             input logic ec, input logic eo);
      int lat;
      in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      checks++; if (lat != 4) $display("FAIL %s_latency got %0d want 4", name, lat); else passes++;
      checks++; if (sum !== es) $display("FAIL %s_sum got %h want %h", name, sum, es); else passes++;
      checks++; if (cout !== ec) $display("FAIL %s_cout got %b want %b", name, cout, ec); else passes++;
      checks++; if (ovf !== eo) $display("FAIL %s_ovf got %b want %b", name, ovf, eo); else passes++;
      $display("%s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               name, ta, tb_, tc, ts, sum, cout, ovf, lat);
      tick();
   endtask

   task automatic test_directed();
      run_single("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_single("sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_single("sub",      16'h0005, 16'h0009, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0);
      run_single("sub_cin",  16'h0005, 16'h0009, 1'b1, 1'b1, 16'hFFFB, 1'b0, 1'b0);
      run_single("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_single("sub_nob",  16'h0009, 16'h0005, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0);
   endtask

   // Streams n ops; random=0 gives back-to-back with a 3-cycle stall.
   task automatic run_stream(input string name, input int n, input bit random_gaps);
      logic [17:0] exp_q[$];
      logic [17:0] exp;
      int sent = 0, recv = 0, cyc = 0;
      while (recv < n && cyc < 20 * n + 40) begin
         if (random_gaps) out_ready = ($urandom_range(0, 2) != 0);
         else             out_ready = !(cyc >= 5 && cyc <= 7);
         if (sent < n && (!random_gaps || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL %s_stall_in_ready cyc %0d got %b want 0", name, cyc, in_ready); else passes++;
            if (exp_q.size() > 0) begin
               checks++;
               if ({ovf, cout, sum} !== exp_q[0])
                  $display("FAIL %s_stall_hold cyc %0d got %h want %h", name, cyc, {ovf, cout, sum}, exp_q[0]);
               else passes++;
            end
         end
         if (!random_gaps && cyc >= 5 && cyc <= 7) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL %s_stall_valid cyc %0d got %b want 1", name, cyc, out_valid); else passes++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL %s_extra_result got %h want none", name, {ovf, cout, sum});
            end else begin
               exp = exp_q.pop_front();
               if ({ovf, cout, sum} !== exp)
                  $display("FAIL %s_result %0d got %h want %h", name, recv, {ovf, cout, sum}, exp);
               else passes++;
               $display("%s: result %0d = %h (expect %h)", name, recv, {ovf, cout, sum}, exp);
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref16(a, b, cin, sub));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (recv != n || sent != n) $display("FAIL %s_count got %0d/%0d want %0d", name, recv, sent, n); else passes++;
   endtask

   task automatic test_back_to_back();
      run_stream("b2b", 8, 1'b0);
   endtask

   task automatic test_random_stream();
      run_stream("rnd", 40, 1'b1);
   endtask

   task automatic test_reset_midstream();
      int stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else passes++;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) stale++;
         tick();
      end
      checks++; if (stale != 0) $display("FAIL midrst_stale got %0d want 0", stale); else passes++;
      $display("midrst: stale results=%0d", stale);
      run_single("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
   endtask

   task automatic one_stage(input string name, input logic [3:0] ta, input logic [3:0] tb_,
                            input logic tc, input logic [3:0] es, input logic ec);
      in_valid1 = 1'b1; a1 = ta; b1 = tb_; cin1 = tc; sub1 = 1'b0; out_ready1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      checks++; if (out_valid1 !== 1'b1) $display("FAIL %s_latency got valid %b want 1", name, out_valid1); else passes++;
      checks++; if (sum1 !== es) $display("FAIL %s_sum got %b want %b", name, sum1, es); else passes++;
      checks++; if (cout1 !== ec) $display("FAIL %s_cout got %b want %b", name, cout1, ec); else passes++;
      checks++; if (ovf1 !== 1'b0) $display("FAIL %s_ovf got %b want 0", name, ovf1); else passes++;
      $display("%s: %0d+%0d+%b -> sum=%b cout=%b", name, ta, tb_, tc, sum1, cout1);
      tick();
   endtask

   task automatic test_single_stage();
      one_stage("w4_a", 4'd4,  4'd10, 1'b1, 4'b1111, 1'b0);
      one_stage("w4_b", 4'd1,  4'd14, 1'b1, 4'b0000, 1'b1);
      one_stage("w4_c", 4'd12, 4'd3,  1'b0, 4'b1111, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      test_random_stream();
      test_single_stage();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
